// File: rtl/video_pkg.sv
// Shared types for the parallel-video to AXI4-Stream front end.
package video_pkg;

  localparam int DATA_WIDTH_DEF = 24;

  typedef logic [DATA_WIDTH_DEF-1:0] pixel_t;

  typedef struct packed {
    logic   tuser;
    logic   tlast;
    pixel_t data;
  } stream_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } state_t;

  // Width needed to index v items; never returns less than 1 so V_ACTIVE=1 still gets a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; reset flushes all state.
module sync_fifo
  import video_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_wr = wr_en && (r_count != FULL_CNT);
  assign w_rd = rd_en && (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rptr];
  assign count = r_count;

endmodule

// File: rtl/video_timing_to_axis.sv
// Parallel video (vsync/de/data) to AXI4-Stream with tuser=SOF, tlast=EOF/EOL,
// elastic FIFO for backpressure, overflow drop and short-frame resync on vsync.
module video_timing_to_axis
  import video_pkg::*;
#(
  parameter int DATA_WIDTH     = 24,
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int FIFO_DEPTH     = 16,
  parameter int TLAST_PER_LINE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vid_vsync,
  input  logic                  vid_de,
  input  logic [DATA_WIDTH-1:0] vid_data,
  output logic                  axis_video_tvalid,
  input  logic                  axis_video_tready,
  output logic [DATA_WIDTH-1:0] axis_video_tdata,
  output logic                  axis_video_tuser,
  output logic                  axis_video_tlast,
  output logic                  ovf_pulse,
  output logic                  frame_err_pulse
);

  localparam int XW = clog2(H_ACTIVE);
  localparam int YW = clog2(V_ACTIVE);
  localparam int CW = clog2(FIFO_DEPTH) + 1;
  localparam int EW = DATA_WIDTH + 2;

  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic                  tuser;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic                  r_vs;
  logic                  r_vs_d;
  logic                  r_de;
  logic [DATA_WIDTH-1:0] r_data;
  state_t                r_state;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic                  r_ovf;
  logic                  r_err;

  logic                  w_rise;
  logic [XW-1:0]         w_x;
  logic [YW-1:0]         w_y;
  logic                  w_x_last;
  logic                  w_y_last;
  logic                  w_take;
  logic                  w_full;
  logic                  w_push;
  logic                  w_ovf;
  logic                  w_pop;
  entry_t                w_in;
  entry_t                w_out;
  logic [EW-1:0]         w_dout;
  logic [CW-1:0]         w_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs   <= 1'b0;
      r_vs_d <= 1'b0;
      r_de   <= 1'b0;
      r_data <= '0;
    end else begin
      r_vs   <= vid_vsync;
      r_vs_d <= r_vs;
      r_de   <= vid_de;
      r_data <= vid_data;
    end
  end

  // A vsync rise restarts the coordinates before the same-cycle pixel is placed.
  assign w_rise   = r_vs & ~r_vs_d;
  assign w_x      = w_rise ? '0 : r_x;
  assign w_y      = w_rise ? '0 : r_y;
  assign w_x_last = (w_x == X_LAST);
  assign w_y_last = (w_y == Y_LAST);

  assign w_take = r_de && (w_rise || (r_state == ACTIVE));
  assign w_full = (w_count == FULL_CNT);
  assign w_push = w_take && !w_full;
  assign w_ovf  = w_take && w_full;

  assign w_in.tuser = (w_x == '0) && (w_y == '0);
  assign w_in.tlast = w_x_last && ((TLAST_PER_LINE != 0) || w_y_last);
  assign w_in.data  = r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      r_err <= w_rise && (r_state == ACTIVE);
      if (w_ovf) begin
        r_ovf   <= 1'b1;
        r_state <= DROP;
        r_x     <= w_x;
        r_y     <= w_y;
      end else if (w_push) begin
        if (w_x_last) begin
          r_x <= '0;
          if (w_y_last) begin
            r_y     <= '0;
            r_state <= IDLE;
          end else begin
            r_y     <= w_y + 1'b1;
            r_state <= ACTIVE;
          end
        end else begin
          r_x     <= w_x + 1'b1;
          r_y     <= w_y;
          r_state <= ACTIVE;
        end
      end else if (w_rise) begin
        r_state <= ACTIVE;
        r_x     <= '0;
        r_y     <= '0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (w_push),
    .din   (w_in),
    .rd_en (w_pop),
    .dout  (w_dout),
    .count (w_count)
  );

  assign w_out             = entry_t'(w_dout);
  assign axis_video_tvalid = (w_count != '0);
  assign w_pop             = axis_video_tvalid && axis_video_tready;
  assign axis_video_tdata  = w_out.data;
  assign axis_video_tuser  = w_out.tuser;
  assign axis_video_tlast  = w_out.tlast;
  assign ovf_pulse         = r_ovf;
  assign frame_err_pulse   = r_err;

endmodule

// File: tb/tb_video_timing_to_axis.sv
// Bench: two instances (A: depth 4, frame tlast; B: depth 16, line tlast) fed the same video.
module tb_video_timing_to_axis;

  localparam int DW = 24;
  localparam int H  = 4;
  localparam int V  = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
  } beat_t;

  typedef struct {
    logic          vs;
    logic          de;
    logic [DW-1:0] d;
    logic          ev;
    logic [DW-1:0] ed;
    logic          eu;
    logic          ela;
    logic          elb;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vs  = 1'b0;
  logic          de  = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rdy = 1'b0;
  int            rdy_mode = 0;

  logic          tv   [2];
  logic [DW-1:0] td   [2];
  logic          tu   [2];
  logic          tl   [2];
  logic          ovf  [2];
  logic          ferr [2];

  beat_t q [2][$];
  int    checks = 0;
  int    errors = 0;
  int    ovf_cnt [2] = '{0, 0};
  int    err_cnt [2] = '{0, 0};
  logic  prev_stall [2] = '{1'b0, 1'b0};
  logic  prev_ovf   [2] = '{1'b0, 1'b0};
  logic  prev_err   [2] = '{1'b0, 1'b0};
  beat_t prev_b     [2];

  vec_t tbl [12];

  always #5 clk = ~clk;

  video_timing_to_axis #(
    .DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(4), .TLAST_PER_LINE(0)
  ) dut_a (
    .clk(clk), .rst(rst), .vid_vsync(vs), .vid_de(de), .vid_data(din),
    .axis_video_tvalid(tv[0]), .axis_video_tready(rdy), .axis_video_tdata(td[0]),
    .axis_video_tuser(tu[0]), .axis_video_tlast(tl[0]),
    .ovf_pulse(ovf[0]), .frame_err_pulse(ferr[0])
  );

  video_timing_to_axis #(
    .DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(16), .TLAST_PER_LINE(1)
  ) dut_b (
    .clk(clk), .rst(rst), .vid_vsync(vs), .vid_de(de), .vid_data(din),
    .axis_video_tvalid(tv[1]), .axis_video_tready(rdy), .axis_video_tdata(td[1]),
    .axis_video_tuser(tu[1]), .axis_video_tlast(tl[1]),
    .ovf_pulse(ovf[1]), .frame_err_pulse(ferr[1])
  );

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: rdy = ~rdy;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pops on every handshake, checks AXIS hold rule and pulse widths.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      beat_t cur;
      beat_t e;
      cur.d = td[k];
      cur.u = tu[k];
      cur.l = tl[k];
      if (rst) begin
        prev_stall[k] = 1'b0;
      end else begin
        if (prev_stall[k])
          chk($sformatf("hold%0d", k), {tv[k], cur.u, cur.l, cur.d},
              {1'b1, prev_b[k].u, prev_b[k].l, prev_b[k].d});
        if (tv[k] && rdy) begin
          checks++;
          if (q[k].size() == 0) begin
            errors++;
            $display("FAIL beat%0d_unexpected: actual data %0h required no beat", k, cur.d);
          end else begin
            e = q[k].pop_front();
            if ({cur.u, cur.l, cur.d} !== {e.u, e.l, e.d}) begin
              errors++;
              $display("FAIL beat%0d: actual u%0b l%0b %0h required u%0b l%0b %0h",
                       k, cur.u, cur.l, cur.d, e.u, e.l, e.d);
            end
          end
        end
        if (ovf[k]) begin
          ovf_cnt[k]++;
          chk($sformatf("ovf_width%0d", k), prev_ovf[k], 0);
        end
        if (ferr[k]) begin
          err_cnt[k]++;
          chk($sformatf("err_width%0d", k), prev_err[k], 0);
        end
        prev_stall[k] = tv[k] && !rdy;
        prev_b[k]     = cur;
      end
      prev_ovf[k] = ovf[k];
      prev_err[k] = ferr[k];
    end
  end

  task automatic cyc(input logic v, input logic d, input logic [DW-1:0] x);
    @(posedge clk);
    #1;
    vs  = v;
    de  = d;
    din = x;
  endtask

  task automatic push(input int k, input int d, input logic u, input logic l);
    beat_t b;
    b.d = DW'(d);
    b.u = u;
    b.l = l;
    q[k].push_back(b);
  endtask

  // vsync pulse, then n pixels; na/nb = how many of them each instance should emit.
  task automatic frame(input int n, input int base, input int gap, input int na, input int nb);
    cyc(1'b1, 1'b0, '0);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, DW'(base + i));
      if (i < na) push(0, base + i, i == 0, i == H*V-1);
      if (i < nb) push(1, base + i, i == 0, (i % H) == H-1);
      if (gap != 0) cyc(1'b0, 1'b0, '0);
    end
    cyc(1'b0, 1'b0, '0);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_drained"}, q[0].size() + q[1].size(), 0);
    repeat (3) @(negedge clk);
    chk({nm, "_idle"}, {tv[0], tv[1]}, 0);
  endtask

  function automatic vec_t mk(int v, int d, int x, int ev, int ed, int eu, int ela, int elb);
    vec_t r;
    r.vs  = (v != 0);
    r.de  = (d != 0);
    r.d   = DW'(x);
    r.ev  = (ev != 0);
    r.ed  = DW'(ed);
    r.eu  = (eu != 0);
    r.ela = (ela != 0);
    r.elb = (elb != 0);
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ob0, ob1, eb0, eb1;
    // cycle-accurate first frame: first beat two cycles after first de
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 2, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 3, 1, 1, 1, 0, 0);
    tbl[4]  = mk(0, 1, 4, 1, 2, 0, 0, 0);
    tbl[5]  = mk(0, 1, 5, 1, 3, 0, 0, 0);
    tbl[6]  = mk(0, 1, 6, 1, 4, 0, 0, 1);
    tbl[7]  = mk(0, 1, 7, 1, 5, 0, 0, 0);
    tbl[8]  = mk(0, 1, 8, 1, 6, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 1, 7, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 1, 8, 0, 1, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst_tvalid", {tv[0], tv[1]}, 0);
    chk("rst_tdata",  td[0], 0);
    chk("rst_tuser",  {tu[0], tu[1]}, 0);
    chk("rst_tlast",  {tl[0], tl[1]}, 0);
    chk("rst_pulses", {ovf[0], ovf[1], ferr[0], ferr[1]}, 0);
    rst = 1'b0;
    @(negedge clk);
    rdy_mode = 1;

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].vs, tbl[i].de, tbl[i].d);
      if (tbl[i].de) begin
        push(0, int'(tbl[i].d), tbl[i].d == 1, tbl[i].d == 8);
        push(1, int'(tbl[i].d), tbl[i].d == 1, tbl[i].d[1:0] == 2'd0);
      end
      @(negedge clk);
      chk($sformatf("tbl%0d_tvalid", i), {tv[0], tv[1]}, {tbl[i].ev, tbl[i].ev});
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_tdata", i), td[0], tbl[i].ed);
        chk($sformatf("tbl%0d_tuser", i), tu[0], tbl[i].eu);
        chk($sformatf("tbl%0d_tlast_a", i), tl[0], tbl[i].ela);
        chk($sformatf("tbl%0d_tlast_b", i), tl[1], tbl[i].elb);
      end
    end
    drain("basic");

    // overflow: A holds 4 and drops to DROP, B keeps the whole frame
    @(negedge clk);
    rdy_mode = 0;
    ob0 = ovf_cnt[0]; ob1 = ovf_cnt[1]; eb0 = err_cnt[0]; eb1 = err_cnt[1];
    frame(8, 'h10, 0, 4, 8);
    repeat (2) cyc(1'b0, 1'b0, '0);
    @(negedge clk);
    chk("ovf_a_count", ovf_cnt[0] - ob0, 1);
    chk("ovf_b_count", ovf_cnt[1] - ob1, 0);
    chk("ovf_held_valid", {tv[0], tv[1]}, 2'b11);
    rdy_mode = 1;
    drain("ovf");
    frame(8, 'h40, 0, 8, 8);
    drain("after_ovf");
    chk("ovf_no_err", (err_cnt[0] - eb0) + (err_cnt[1] - eb1), 0);

    // short frame: vsync after 3 pixels restarts the frame
    eb0 = err_cnt[0]; eb1 = err_cnt[1];
    frame(3, 'h20, 0, 3, 3);
    frame(8, 'h30, 0, 8, 8);
    drain("short");
    chk("short_err_a", err_cnt[0] - eb0, 1);
    chk("short_err_b", err_cnt[1] - eb1, 1);

    // vsync rise coincident with de: that pixel is (0,0)
    eb0 = err_cnt[0];
    cyc(1'b1, 1'b1, DW'('h55));
    push(0, 'h55, 1'b1, 1'b0);
    push(1, 'h55, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      cyc(1'b0, 1'b1, DW'('h55 + i));
      push(0, 'h55 + i, 1'b0, i == 7);
      push(1, 'h55 + i, 1'b0, (i % H) == H-1);
    end
    cyc(1'b0, 1'b0, '0);
    drain("vs_de");
    chk("vs_de_no_err", err_cnt[0] - eb0, 0);

    // tready toggling, pixels every other cycle
    @(negedge clk);
    rdy_mode = 2;
    ob0 = ovf_cnt[0];
    frame(8, 'h60, 1, 8, 8);
    repeat (4) cyc(1'b0, 1'b0, '0);
    @(negedge clk);
    rdy_mode = 1;
    drain("toggle");
    chk("toggle_no_ovf", ovf_cnt[0] - ob0, 0);

    // reset mid-frame with 3 entries buffered
    @(negedge clk);
    rdy_mode = 0;
    cyc(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, DW'('h70 + i));
    repeat (3) cyc(1'b0, 1'b0, '0);
    @(negedge clk);
    chk("pre_rst_valid", tv[0], 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_tvalid", {tv[0], tv[1]}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rdy_mode = 1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, DW'('h80 + i));
    repeat (6) cyc(1'b0, 1'b0, '0);
    @(negedge clk);
    chk("post_rst_quiet", {tv[0], tv[1]}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_to_axis.md
# video_timing_to_axis

Front-end stage ahead of the video-to-AXI write driver. It converts raw parallel video (vsync/de/pixel bus) into an AXI4-Stream pixel stream with tuser marking start-of-frame and tlast marking end-of-frame (or end-of-line), through a small elastic FIFO that absorbs downstream backpressure. Frames that overflow the FIFO or end early are flagged and resynchronised at the next vsync.

## Interface
- DATA_WIDTH, 24: pixel width (RGB888).
- H_ACTIVE, 640: active pixels per line, ≥2.
- V_ACTIVE, 480: active lines per frame, ≥1.
- FIFO_DEPTH, 16: elastic FIFO entries, power of two, ≥4.
- TLAST_PER_LINE, 0: 0 = tlast on last pixel of frame; 1 = tlast on last pixel of every line.
- clk  in  1  single clock for video input and stream output.
- rst  in  1  reset, asynchronous, active-high.
- vid_vsync  in  1  frame sync, active-high; frame starts on rising edge.
- vid_de  in  1  data enable, one pixel per cycle while high.
- vid_data  in  DATA_WIDTH  pixel, valid when vid_de=1.
- axis_video_tvalid  out  1  stream valid.
- axis_video_tready  in  1  stream ready.
- axis_video_tdata  out  DATA_WIDTH  pixel.
- axis_video_tuser  out  1  first pixel of frame (x=0,y=0).
- axis_video_tlast  out  1  end marker per TLAST_PER_LINE.
- ovf_pulse  out  1  one-cycle pulse: pixel lost to full FIFO.
- frame_err_pulse  out  1  one-cycle pulse: vsync arrived before frame completed.

## Operation
- Input stage: vid_vsync, vid_de, vid_data registered once; vsync rising edge detected on registered value (vsync_r & ~vsync_rr).
- Counters: x in [0,H_ACTIVE-1], y in [0,V_ACTIVE-1], width clog2 of each; x wraps to 0 and y increments on each accepted pixel with x==H_ACTIVE-1.
- FIFO entry = {tuser, tlast, data}; tuser = (x==0 && y==0); tlast = (x==H_ACTIVE-1) && (TLAST_PER_LINE || y==V_ACTIVE-1).
- States:
  - IDLE (reset state): de ignored; vsync rise → ACTIVE, x=y=0.
  - ACTIVE: each registered de pushes one entry. Push of last frame pixel (x=H-1, y=V-1) → IDLE. de while FIFO full → pixel discarded, ovf_pulse, → DROP. vsync rise → frame_err_pulse, x=y=0, stay ACTIVE (short frame gets no end tlast).
  - DROP: de ignored; FIFO keeps draining; vsync rise → ACTIVE, x=y=0. No frame_err in DROP.
- de in IDLE (extra pixels after frame end) silently ignored.
- Full check uses the current count only: push rejected when count==FIFO_DEPTH even if a pop occurs the same cycle.
- Simultaneous push and pop with count<FIFO_DEPTH: count unchanged, both take effect.
- Simultaneous vsync rise and de: the vsync is processed first; that pixel becomes x=0,y=0 of the new frame.

## Timing
- Reset values: all outputs 0; state IDLE; FIFO empty; counters 0.
- Reset mid-frame: FIFO flushed immediately (tvalid drops asynchronously to 0); resumes only after a subsequent vsync rise.
- Latency: pixel on vid_data at cycle N → input reg N+1 → FIFO write N+1 → tvalid at N+2 if FIFO previously empty.
- Throughput: one pixel per cycle sustained with tready=1.
- AXIS rule: once tvalid=1, tvalid/tdata/tuser/tlast hold until tready=1; pop on tvalid&&tready.
- Pulse outputs registered, high exactly one cycle, one cycle after the offending input-stage cycle.

## Structure
- Shared package video_pkg: pixel type (DATA_WIDTH), stream entry struct {tuser, tlast, data}, state enum {IDLE, ACTIVE, DROP}, clog2 function.
- One sub-module, sync_fifo (parameterised width/depth, first-word-fall-through, count output); timing capture, counters and FSM stay in the top.

## Test plan
- H=4,V=2,TLAST_PER_LINE=0, tready=1: vsync rise then 8 de pixels 0x000001..0x000008 → 8 beats, tuser only on 0x000001, tlast only on 0x000008, first tvalid 2 cycles after first de.
- Same with TLAST_PER_LINE=1 → tlast on 0x000004 and 0x000008.
- FIFO_DEPTH=4, tready=0, frame of 8 pixels → 4 entries held, ovf_pulse once on 5th pixel, state DROP; tready=1 → exactly 4 beats out; next vsync + frame → clean 8-beat frame.
- vsync rise after 3 of 8 pixels → frame_err_pulse once, next pixel carries tuser, full new frame follows with correct tlast.
- tready toggling 1/0 every cycle on a full frame → no data lost or duplicated, outputs stable while stalled.
- rst asserted with FIFO holding 3 entries → tvalid=0 immediately; de without vsync after release produces no output.
